// File: rtl/ftnn_pkg.sv
// Shared types and constants for the TMR first-layer neuron datapath.
// Weight words are n-bit 6.10 fixed point followed by a cl-bit CRC.
package ftnn_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CAPT,
      S_EVAL,
      S_DONE
   } fetch_state_e;

   localparam int DEF_M    = 8;
   localparam int DEF_N    = 16;
   localparam int DEF_CL   = 8;
   localparam int INTBITS  = 6;
   localparam int FRACBITS = 10;
   localparam int WORD_W   = DEF_N + DEF_CL;

endpackage

// File: rtl/wcrc_fetch.sv
// Weight-fetch stage: loads M CRC-protected words into the flat Wcrc bus
// and re-fetches the set when the neuron reports a CRC/voting error.
module wcrc_fetch
   import ftnn_pkg::*;
#(
   parameter int M        = DEF_M,
   parameter int n        = DEF_N,
   parameter int cl       = DEF_CL,
   parameter int AW       = 8,
   parameter int EVAL_CYC = 1,
   parameter int MAXRETRY = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [AW-1:0]     base_addr,
   output logic              mem_rd,
   output logic [AW-1:0]     mem_addr,
   input  logic [n+cl-1:0]   mem_rdata,
   input  logic              rfflag,
   input  logic              invalid,
   output logic [M*(n+cl)-1:0] Wcrc,
   output logic              wvalid,
   output logic              busy,
   output logic              done,
   output logic              fault,
   output logic [1:0]        retry_cnt
);

   localparam int W  = n + cl;
   localparam int CW = (M > 1) ? $clog2(M) : 1;
   localparam int EW = (EVAL_CYC > 1) ? $clog2(EVAL_CYC) : 1;
   localparam logic [CW-1:0] KLAST = CW'(M - 1);
   localparam logic [EW-1:0] ELAST = EW'(EVAL_CYC - 1);
   localparam logic [1:0]    RMAX  = 2'(MAXRETRY);

   fetch_state_e       state_q;
   logic [AW-1:0]      base_q;
   logic [AW-1:0]      addr_q;
   logic               rd_q;
   logic [CW-1:0]      k_q;
   logic               pend_q;
   logic [CW-1:0]      pidx_q;
   logic [EW-1:0]      ecnt_q;
   logic [1:0]         retry_q;
   logic               wvalid_q;
   logic               done_q;
   logic               fault_q;
   logic [M*W-1:0]     wcrc_q;

   logic               err;
   assign err = rfflag | invalid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         base_q   <= '0;
         addr_q   <= '0;
         rd_q     <= 1'b0;
         k_q      <= '0;
         pend_q   <= 1'b0;
         pidx_q   <= '0;
         ecnt_q   <= '0;
         retry_q  <= '0;
         wvalid_q <= 1'b0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
         wcrc_q   <= '0;
      end else begin
         // Read data lags the strobe by one cycle; track it with its slot.
         pend_q <= rd_q;
         pidx_q <= k_q;
         if (pend_q) begin
            wcrc_q[pidx_q*W +: W] <= mem_rdata;
         end

         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  base_q   <= base_addr;
                  addr_q   <= base_addr;
                  rd_q     <= 1'b1;
                  k_q      <= '0;
                  fault_q  <= 1'b0;
                  retry_q  <= '0;
                  wvalid_q <= 1'b0;
                  state_q  <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (k_q == KLAST) begin
                  rd_q    <= 1'b0;
                  state_q <= S_CAPT;
               end else begin
                  k_q    <= k_q + 1'b1;
                  addr_q <= base_q + AW'(k_q) + AW'(1);
               end
            end
            S_CAPT: begin
               wvalid_q <= 1'b1;
               ecnt_q   <= '0;
               state_q  <= S_EVAL;
            end
            S_EVAL: begin
               if (ecnt_q != ELAST) begin
                  ecnt_q <= ecnt_q + 1'b1;
               end else if (err && retry_q < RMAX) begin
                  retry_q  <= retry_q + 1'b1;
                  wvalid_q <= 1'b0;
                  addr_q   <= base_q;
                  rd_q     <= 1'b1;
                  k_q      <= '0;
                  state_q  <= S_FETCH;
               end else begin
                  if (err) begin
                     fault_q  <= 1'b1;
                     wvalid_q <= 1'b0;
                  end
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_rd    = rd_q;
   assign mem_addr  = addr_q;
   assign Wcrc      = wcrc_q;
   assign wvalid    = wvalid_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;

endmodule

// File: tb/tb_wcrc_fetch.sv
// Directed bench for wcrc_fetch with a synchronous weight-memory model.
// Expected values are hand-written constants from the weight tables.
module tb_wcrc_fetch;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [7:0]    base_addr = '0;
   logic          mem_rd;
   logic [7:0]    mem_addr;
   logic [23:0]   mem_rdata = '0;
   logic          rfflag = 1'b0;
   logic          invalid = 1'b0;
   logic [191:0]  Wcrc;
   logic          wvalid;
   logic          busy;
   logic          done;
   logic          fault;
   logic [1:0]    retry_cnt;

   logic [23:0]   mem [256];

   int checks = 0;
   int errors = 0;
   int rd_cnt, done_cnt, done_cyc, wv_cyc, refetch_cyc;
   logic          prev_rd;
   logic [7:0]    addrs [8];
   logic [23:0]   slot0_first;

   localparam logic [191:0] CLEAN = {
      24'h806689, 24'h006600, 24'h806689, 24'h806689,
      24'h006600, 24'h806689, 24'h006600, 24'h006600};
   localparam logic [191:0] FIXED = {
      24'h806689, 24'h006600, 24'h806689, 24'h806689,
      24'h006600, 24'h806689, 24'h006600, 24'h806689};
   localparam logic [191:0] WRAP = {
      24'h006600, 24'h806689, 24'h006600, 24'h806689,
      24'h444444, 24'h333333, 24'h222222, 24'h111111};

   wcrc_fetch dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .rfflag    (rfflag),
      .invalid   (invalid),
      .Wcrc      (Wcrc),
      .wvalid    (wvalid),
      .busy      (busy),
      .done      (done),
      .fault     (fault),
      .retry_cnt (retry_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string tag, input logic [191:0] obs,
                      input logic [191:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Mode 0 clean, 1 single retry, 2 persistent error, 3 start while busy.
   task automatic run_req(input logic [7:0] base, input int mode);
      rd_cnt = 0; done_cnt = 0; done_cyc = -1;
      wv_cyc = -1; refetch_cyc = -1; prev_rd = 1'b0;
      slot0_first = '0;
      for (int i = 0; i < 8; i++) addrs[i] = '0;
      base_addr = base;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         if (mem_rd) begin
            if (rd_cnt < 8) addrs[rd_cnt] = mem_addr;
            rd_cnt++;
            if (!prev_rd && c > 1 && refetch_cyc < 0) refetch_cyc = c;
         end
         prev_rd = mem_rd;
         if (wvalid && wv_cyc < 0) wv_cyc = c;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (mode == 1 && c == 2) mem[0] = 24'h806689;
         if (mode == 1 && c == 10) slot0_first = Wcrc[23:0];
         rfflag = (mode == 2) || (mode == 1 && c == 10);
         start = (mode == 3) && (c == 3 || c == 11);
         if (done_cyc > 0 && c >= done_cyc + 3) break;
         tick();
      end
      rfflag = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[0] = 24'h006600; mem[1] = 24'h006600;
      mem[2] = 24'h806689; mem[3] = 24'h006600;
      mem[4] = 24'h806689; mem[5] = 24'h806689;
      mem[6] = 24'h006600; mem[7] = 24'h806689;
      mem[8'hFC] = 24'h111111; mem[8'hFD] = 24'h222222;
      mem[8'hFE] = 24'h333333; mem[8'hFF] = 24'h444444;

      #1;
      chk("rst_wcrc", Wcrc, '0);
      chk("rst_flags", {188'(0), wvalid, busy, done, fault},
          '0);
      chk("rst_mem", {183'(0), mem_rd, mem_addr}, '0);
      chk("rst_retry", 192'(retry_cnt), 192'(0));
      tick();
      tick();
      rst = 1'b0;
      tick();

      run_req(8'h00, 0);
      chk("clean_wcrc", Wcrc, CLEAN);
      chk("clean_wvalid_cyc", 192'(wv_cyc), 192'(10));
      chk("clean_done_cyc", 192'(done_cyc), 192'(11));
      chk("clean_done_cnt", 192'(done_cnt), 192'(1));
      chk("clean_rd_cnt", 192'(rd_cnt), 192'(8));
      chk("clean_retry", 192'(retry_cnt), 192'(0));
      chk("clean_hold", {190'(0), wvalid, busy}, 192'(2));

      mem[0] = 24'h816689;
      run_req(8'h00, 1);
      chk("retry_first_slot0", 192'(slot0_first), 192'(24'h816689));
      chk("retry_refetch_cyc", 192'(refetch_cyc), 192'(11));
      chk("retry_done_cyc", 192'(done_cyc), 192'(21));
      chk("retry_rd_cnt", 192'(rd_cnt), 192'(16));
      chk("retry_cnt", 192'(retry_cnt), 192'(1));
      chk("retry_fault", 192'(fault), 192'(0));
      chk("retry_wcrc", Wcrc, FIXED);
      chk("retry_wvalid", 192'(wvalid), 192'(1));

      run_req(8'h00, 2);
      chk("pers_rd_cnt", 192'(rd_cnt), 192'(32));
      chk("pers_done_cyc", 192'(done_cyc), 192'(41));
      chk("pers_retry", 192'(retry_cnt), 192'(3));
      chk("pers_fault", 192'(fault), 192'(1));
      chk("pers_wvalid", 192'(wvalid), 192'(0));

      run_req(8'hFC, 0);
      chk("wrap_a0", 192'(addrs[0]), 192'(8'hFC));
      chk("wrap_a3", 192'(addrs[3]), 192'(8'hFF));
      chk("wrap_a4", 192'(addrs[4]), 192'(8'h00));
      chk("wrap_a7", 192'(addrs[7]), 192'(8'h03));
      chk("wrap_wcrc", Wcrc, WRAP);
      chk("wrap_fault_clr", 192'(fault), 192'(0));
      chk("wrap_done_cyc", 192'(done_cyc), 192'(11));

      mem[0] = 24'h006600;
      run_req(8'h00, 3);
      chk("busy_done_cnt", 192'(done_cnt), 192'(1));
      chk("busy_rd_cnt", 192'(rd_cnt), 192'(8));
      chk("busy_idle", 192'(busy), 192'(0));

      base_addr = 8'h00;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk("mid_busy", 192'(busy), 192'(1));
      rst = 1'b1;
      #1;
      chk("mid_rst_wcrc", Wcrc, '0);
      chk("mid_rst_flags", {188'(0), wvalid, busy, done, fault},
          '0);
      chk("mid_rst_mem", {183'(0), mem_rd, mem_addr}, '0);
      tick();
      rst = 1'b0;
      tick();
      chk("mid_after_wcrc", Wcrc, '0);
      run_req(8'h00, 0);
      chk("mid_done_cyc", 192'(done_cyc), 192'(11));
      chk("mid_wcrc", Wcrc, CLEAN);
      chk("mid_rd_cnt", 192'(rd_cnt), 192'(8));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
